// File: rtl/unidad_riesgos_carga.sv
// unidad_riesgos_carga: load-use hazard scoreboard that stalls ID on pending loads and flags MEM-return forwarding.
module unidad_riesgos_carga #(
  parameter int NREG     = 16,
  parameter int REG_W    = 4,
  parameter int MAX_PEND = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_usa_a,
  input  logic             id_usa_b,
  input  logic             id_es_load,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_done,
  input  logic [REG_W-1:0] mem_rd,
  output logic             stall,
  output logic             adelantar_a,
  output logic             adelantar_b,
  output logic [2:0]       pend_count,
  output logic [15:0]      ciclos_stall,
  output logic             err_espurio,
  output logic             err_timeout
);
  localparam logic [1:0] LIBRE  = 2'd0;
  localparam logic [1:0] ESPERA = 2'd1;
  localparam logic [1:0] ERROR  = 2'd2;

  logic [NREG-1:0] pending;
  logic [1:0]      estado;
  logic [7:0]      cnt;
  logic            issue, retorno, espurio;
  logic            hazardA, hazardB, lleno;
  logic            retA, retB, exA, exB;

  assign issue   = ex_load && ex_rd != '0;
  assign retorno = mem_done && mem_rd != '0 && pending[mem_rd];
  assign espurio = mem_done && (mem_rd == '0 || !pending[mem_rd]);

  assign retA = mem_done && mem_rd == id_ra;
  assign retB = mem_done && mem_rd == id_rb;
  assign exA  = ex_load && ex_rd == id_ra;
  assign exB  = ex_load && ex_rd == id_rb;

  assign hazardA = id_ra != '0 && ((pending[id_ra] && !retA) || exA);
  assign hazardB = id_rb != '0 && ((pending[id_rb] && !retB) || exB);
  assign lleno   = id_es_load && pend_count == 3'(MAX_PEND) && !mem_done;

  assign stall = id_valid && ((id_usa_a && hazardA) || (id_usa_b && hazardB) || lleno);

  // A load re-issuing in EX to the returning register supersedes the returned data.
  assign adelantar_a = id_valid && id_usa_a && id_ra != '0 && retA && pending[id_ra] && !exA;
  assign adelantar_b = id_valid && id_usa_b && id_rb != '0 && retB && pending[id_rb] && !exB;

  assign err_timeout = estado == ERROR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (retorno) pending[mem_rd] <= 1'b0;
      if (issue) pending[ex_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_count   <= 3'd0;
      ciclos_stall <= 16'd0;
      err_espurio  <= 1'b0;
    end else begin
      pend_count   <= (issue && !retorno && pend_count != 3'(MAX_PEND)) ? pend_count + 3'd1 :
                      (!issue && retorno && pend_count != 3'd0) ? pend_count - 3'd1 : pend_count;
      ciclos_stall <= (stall && ciclos_stall != 16'hFFFF) ? ciclos_stall + 16'd1 : ciclos_stall;
      err_espurio  <= err_espurio || espurio;
    end
  end

  // cnt holds the number of consecutive stalled cycles seen so far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= LIBRE;
      cnt    <= 8'd0;
    end else begin
      case (estado)
        LIBRE: begin
          estado <= stall ? ESPERA : LIBRE;
          cnt    <= stall ? 8'd1 : 8'd0;
        end
        ESPERA: begin
          estado <= !stall ? LIBRE : (cnt == 8'(TIMEOUT - 1)) ? ERROR : ESPERA;
          cnt    <= !stall ? 8'd0 : (cnt == 8'(TIMEOUT - 1)) ? cnt : cnt + 8'd1;
        end
        default: begin
          estado <= ERROR;
          cnt    <= cnt;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_unidad_riesgos_carga.sv
// tb_unidad_riesgos_carga: directed scoreboard bench for the load-use hazard unit.
module tb_unidad_riesgos_carga;
  logic clk = 1'b0;
  logic rst_n;
  logic idValid, idUsaA, idUsaB, idEsLoad, exLoad, memDone;
  logic [3:0] idRa, idRb, exRd, memRd;
  logic stall, adelA, adelB, espurio, timeoutErr;
  logic [2:0] pendCount;
  logic [15:0] ciclos;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] exp;
  } item_t;
  item_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unidad_riesgos_carga dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(idValid), .id_ra(idRa), .id_rb(idRb),
    .id_usa_a(idUsaA), .id_usa_b(idUsaB), .id_es_load(idEsLoad),
    .ex_load(exLoad), .ex_rd(exRd), .mem_done(memDone), .mem_rd(memRd),
    .stall(stall), .adelantar_a(adelA), .adelantar_b(adelB),
    .pend_count(pendCount), .ciclos_stall(ciclos),
    .err_espurio(espurio), .err_timeout(timeoutErr)
  );

  function automatic logic [15:0] obsOf(int s);
    return s == 0 ? {15'd0, stall} : s == 1 ? {15'd0, adelA} : s == 2 ? {15'd0, adelB} :
           s == 3 ? {13'd0, pendCount} : s == 4 ? ciclos : s == 5 ? {15'd0, espurio} :
           {15'd0, timeoutErr};
  endfunction

  task automatic ex(string t, int s, logic [15:0] v);
    item_t it;
    it.tag = t;
    it.sig = s;
    it.exp = v;
    q.push_back(it);
  endtask

  task automatic compare();
    item_t it;
    logic [15:0] o;
    while (q.size() > 0) begin
      it = q.pop_front();
      o = obsOf(it.sig);
      checks++;
      assert (o === it.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", it.tag, o, it.exp);
      end
    end
  endtask

  task automatic go();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idValid = 0; idUsaA = 0; idUsaB = 0; idEsLoad = 0; idRa = 0; idRb = 0;
    exLoad = 0; exRd = 0; memDone = 0; memRd = 0;
  endtask

  task automatic doReset();
    rst_n = 0;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2;
    ex("rst_stall", 0, 0); ex("rst_adelA", 1, 0); ex("rst_adelB", 2, 0); ex("rst_pend", 3, 0);
    ex("rst_ciclos", 4, 0); ex("rst_esp", 5, 0); ex("rst_tmo", 6, 0);
    compare();
    doReset();

    idValid = 1; idRa = 7; idRb = 1; idUsaA = 1; idUsaB = 1; exLoad = 1; exRd = 7;
    ex("ex_hazard_stall", 0, 1); ex("ex_hazard_adelA", 1, 0);
    go();
    exLoad = 0;
    ex("pend_hold_stall", 0, 1); ex("pend_one", 3, 1); ex("ciclos_one", 4, 1);
    go();
    memDone = 1; memRd = 7;
    ex("ret7_stall", 0, 0); ex("ret7_adelA", 1, 1); ex("ret7_adelB", 2, 0); ex("ret7_pend", 3, 1);
    go();
    idle();
    ex("after_ret7_pend", 3, 0); ex("after_ret7_ciclos", 4, 2);
    go();

    exLoad = 1; exRd = 5;
    ex("issue5_nostall", 0, 0);
    go();
    idle();
    idValid = 1; idRa = 3; idRb = 5; idUsaA = 1; idUsaB = 1;
    ex("dep_b_stall", 0, 1); ex("dep_b_pend", 3, 1);
    go();
    memDone = 1; memRd = 5;
    ex("ret5_stall", 0, 0); ex("ret5_adelB", 2, 1); ex("ret5_adelA", 1, 0);
    go();
    idle();
    idValid = 1; idUsaA = 1; idUsaB = 1; exLoad = 1; exRd = 0;
    ex("r0_nostall", 0, 0); ex("r0_pend_before", 3, 0);
    go();
    idle();
    ex("r0_pend", 3, 0); ex("ciclos_three", 4, 3);
    go();

    for (int r = 2; r <= 5; r++) begin
      exLoad = 1; exRd = 4'(r);
      go();
    end
    idle();
    idValid = 1; idEsLoad = 1;
    ex("full_stall", 0, 1); ex("full_pend", 3, 4);
    go();
    memDone = 1; memRd = 2; exLoad = 1; exRd = 6;
    ex("full_ret_stall", 0, 0);
    go();
    idle();
    ex("full_swap_pend", 3, 4); ex("full_ciclos", 4, 4);
    for (int r = 3; r <= 6; r++) begin
      memDone = 1; memRd = 4'(r);
      go();
    end
    idle();
    ex("drain_pend", 3, 0); ex("drain_esp", 5, 0);
    go();

    memDone = 1; memRd = 9;
    ex("spur_before", 5, 0);
    go();
    idle();
    ex("spur_set", 5, 1); ex("spur_pend", 3, 0);
    go();
    ex("spur_sticky", 5, 1);
    go();

    doReset();
    ex("rst2_esp", 5, 0); ex("rst2_ciclos", 4, 0);
    compare();
    exLoad = 1; exRd = 8;
    go();
    idle();
    idValid = 1; idRa = 8; idUsaA = 1;
    for (int i = 0; i < 63; i++) go();
    ex("tmo_63_stall", 0, 1); ex("tmo_63_flag", 6, 0); ex("tmo_63_ciclos", 4, 63);
    go();
    ex("tmo_stall", 0, 1); ex("tmo_flag", 6, 1); ex("tmo_ciclos", 4, 64);
    @(negedge clk);
    compare();
    #2;
    rst_n = 0;
    #1;
    ex("arst_stall", 0, 0); ex("arst_pend", 3, 0); ex("arst_ciclos", 4, 0); ex("arst_tmo", 6, 0);
    compare();
    @(posedge clk);
    #1;
    rst_n = 1;
    idle();
    go();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/unidad_riesgos_carga.md
Name: unidad_riesgos_carga

Overview:
- Load-use hazard and scoreboard controller for the pipelined core.
- It is the producer side of the MEM-stage forwarding check. It tracks which registers have loads in flight between EX issue and memory return.
- It stalls ID while a decoded source depends on a pending load, and flags same-cycle forwarding when the load data returns.
- Sits between ID, EX and the memory response path. It drives the pipeline stall and the ID forward selects.

Parameters:
- NREG, 16, number of architectural registers; R0 is hardwired zero.
- REG_W, 4, register index width (log2 NREG).
- MAX_PEND, 4, maximum outstanding loads.
- TIMEOUT, 64, consecutive stall cycles before the timeout error.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  valid instruction in ID.
- id_ra  input  REG_W  ID source A.
- id_rb  input  REG_W  ID source B.
- id_usa_a  input  1  ID instruction reads source A.
- id_usa_b  input  1  ID instruction reads source B.
- id_es_load  input  1  ID instruction is a load.
- ex_load  input  1  load issuing from EX this cycle.
- ex_rd  input  REG_W  destination of the EX load.
- mem_done  input  1  load data returned this cycle.
- mem_rd  input  REG_W  destination of the returned load.
- stall  output  1  freeze PC/IF/ID, inject bubble into EX.
- adelantar_a  output  1  forward mem data to ID operand A.
- adelantar_b  output  1  forward mem data to ID operand B.
- pend_count  output  3  outstanding loads (0..MAX_PEND).
- ciclos_stall  output  16  saturating count of stalled cycles.
- err_espurio  output  1  sticky: mem_done for a non-pending register.
- err_timeout  output  1  sticky: stall exceeded TIMEOUT cycles.

Behaviour:
- Reset (async, rst_n=0): pending[] all 0, pend_count=0, ciclos_stall=0, err_espurio=0, err_timeout=0, FSM=LIBRE. Combinational outputs then follow the cleared state: stall=0 and adelantar_a/b=0 unless inputs create a same-cycle EX hazard.
- Reset mid-stall: all state is discarded, so the stall drops in that same cycle.
- Scoreboard (registered):
  - ex_load=1 with ex_rd!=0 sets pending[ex_rd].
  - mem_done=1 with pending[mem_rd]=1 clears it.
  - If the same register is set and cleared in one cycle, set wins (the new load is outstanding).
  - A load to R0 is never tracked.
- pend_count (registered):
  - +1 on a tracked issue, -1 on a valid return; both in one cycle leaves it unchanged.
  - Never below 0 or above MAX_PEND.
  - When full, an issue without a matching return is impossible because of the full stall.
- Hazard on source X (combinational), where X is ra or rb:
  - Condition 1: X!=0 and pending[X] and not (mem_done and mem_rd==X).
  - Condition 2: X!=0 and ex_load and ex_rd==X.
- stall (combinational) = id_valid and any of:
  - id_usa_a and hazard_a;
  - id_usa_b and hazard_b;
  - id_es_load and pend_count==MAX_PEND and not mem_done.
- adelantar_a = id_valid and id_usa_a and id_ra!=0 and mem_done and mem_rd==id_ra and pending[id_ra] and not (ex_load and ex_rd==id_ra). adelantar_b is the same form for id_rb.
- Forwarding is zero-latency. On the return cycle, ID proceeds without stall.
- err_espurio: set on the clock edge where mem_done=1 and (mem_rd==0 or pending[mem_rd]=0). The scoreboard is unchanged in that case. Cleared only by reset.
- ciclos_stall: increments each cycle stall=1 and saturates at 0xFFFF.
- FSM and timeout (registered state, 8-bit counter cnt):
  - LIBRE: cnt=0. Go to ESPERA when stall=1.
  - ESPERA: cnt+1 per stalled cycle. Return to LIBRE when stall=0. Go to ERROR when cnt reaches TIMEOUT-1 with stall still 1.
  - ERROR: err_timeout=1. Stall logic keeps operating normally. Leaves only on reset.

Test Plan:
- Reset with all inputs 0 -> stall=0, adelantar_a=adelantar_b=0, pend_count=0, ciclos_stall=0, both errors 0.
- EX load ex_rd=7, next cycle ID ra=7, rb=1 (usa_a=usa_b=1) -> stall=1 the same cycle as the load. Stall holds while mem_done=0. When mem_done with mem_rd=7: stall=0, adelantar_a=1, adelantar_b=0, pend_count 1->0.
- Pending load on R5, ID ra=3, rb=5 -> stall=1. With mem_done/mem_rd=5 -> adelantar_b=1, adelantar_a=0. Load on R0 -> no stall, pend_count stays 0.
- Issue 4 loads to R2..R5, then ID load with no dependence -> stall=1 (full). Same cycle mem_done mem_rd=2 -> stall=0, pend_count stays 4 after a new issue.
- mem_done with mem_rd=9 while pending[9]=0 -> err_espurio=1 next edge and sticky; pend_count unchanged.
- Hold dependence for 64 cycles -> err_timeout=1, ciclos_stall=64. Async rst_n pulse mid-stall -> all outputs cleared immediately.
